// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared constants and FSM encoding for the NES/SNES pad emulator
// Contents: button bit positions, frame lengths, controller state encoding.
package nes_pkg;

    // Bit positions in the button vector; bit 0 is the first bit on the wire.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NES_BITS  = 8;
    localparam int SNES_BITS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } nes_state_e;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-stage synchroniser with level and edge outputs
// Ports: clk, rst_n (sync, active-low), async_i (asynchronous pin),
//        level_o (synchronised level), rise_o / fall_o (one-cycle edge strobes).
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_dly_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q      <= '0;
            level_dly_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], async_i};
            level_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Edge strobes are combinational from flops only, so no pin-to-output path.
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~level_dly_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & level_dly_q;

endmodule

// File: rtl/nes_controller_emulator.sv
// rtl/nes_controller_emulator.sv - device end of the NES/SNES serial pad protocol
// Ports: clk, rst_n (sync, active-low), buttons (active-high, bit0 first),
//        nes_latch / nes_clk (async from console), nes_data (active-low serial),
//        busy (LOAD or SHIFT), bit_count (bits shifted, saturating), frame_done (pulse).
module nes_controller_emulator
    import nes_pkg::*;
#(
    parameter int   NUM_BITS    = 8,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_LEVEL  = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BITS-1:0] buttons,
    input  logic                nes_latch,
    input  logic                nes_clk,
    output logic                nes_data,
    output logic                busy,
    output logic [4:0]          bit_count,
    output logic                frame_done
);

    localparam logic [4:0] LAST_COUNT = 5'(NUM_BITS);

    logic latch_s, latch_rise, latch_fall;
    logic clk_s, clk_rise, clk_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (nes_latch),
        .level_o (latch_s),
        .rise_o  (latch_rise),
        .fall_o  (latch_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (nes_clk),
        .level_o (clk_s),
        .rise_o  (clk_rise),
        .fall_o  (clk_fall)
    );

    // The FSM works on levels for latch and on the rising edge of the shift clock.
    logic unused_edges;
    assign unused_edges = &{1'b0, latch_rise, latch_fall, clk_s, clk_fall};

    nes_state_e          state_q, state_d;
    logic [NUM_BITS-1:0] shreg_q, shreg_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                done_q, done_d;

    // Shift right with the fill level entering at the top; the extended vector
    // keeps the slice legal for NUM_BITS == 1.
    logic [NUM_BITS:0]   shift_ext;
    logic [NUM_BITS-1:0] shreg_shifted;
    logic [4:0]          cnt_inc;

    assign shift_ext     = {FILL_LEVEL, shreg_q};
    assign shreg_shifted = shift_ext[NUM_BITS:1];
    assign cnt_inc       = cnt_q + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        // Latch has priority over any shift edge in every state; the frame value
        // is whatever buttons hold on the last cycle latch_s is still high.
        if (latch_s) begin
            state_d = LOAD;
            shreg_d = ~buttons;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                LOAD: state_d = SHIFT;
                SHIFT: begin
                    if (clk_rise) begin
                        shreg_d = shreg_shifted;
                        cnt_d   = cnt_inc;
                        if (cnt_inc == LAST_COUNT) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        nes_data = 1'b1;
        case (state_q)
            LOAD, SHIFT: nes_data = shreg_q[0];
            DONE:        nes_data = FILL_LEVEL;
            default:     nes_data = 1'b1;
        endcase
    end

    assign busy       = (state_q == LOAD) || (state_q == SHIFT);
    assign bit_count  = cnt_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_nes_controller_emulator.sv
// tb/tb_nes_controller_emulator.sv - scoreboard bench for NES (8-bit) and SNES (16-bit) instances
module tb_nes_controller_emulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] btn;
    logic        nes_latch;
    logic        nes_clk;

    logic       d8, busy8, fd8;
    logic [4:0] bc8;
    logic       d16, busy16, fd16;
    logic [4:0] bc16;

    nes_controller_emulator #(.NUM_BITS(8)) u_nes (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons    (btn[7:0]),
        .nes_latch  (nes_latch),
        .nes_clk    (nes_clk),
        .nes_data   (d8),
        .busy       (busy8),
        .bit_count  (bc8),
        .frame_done (fd8)
    );

    nes_controller_emulator #(.NUM_BITS(16)) u_snes (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons    (btn),
        .nes_latch  (nes_latch),
        .nes_clk    (nes_clk),
        .nes_data   (d16),
        .busy       (busy16),
        .bit_count  (bc16),
        .frame_done (fd16)
    );

    always #20 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // frame_done is counted on the posedge that ends the cycle it was high in.
    int fd_cnt8 = 0;
    int fd_cnt16 = 0;
    always @(posedge clk) begin
        if (fd8)  fd_cnt8++;
        if (fd16) fd_cnt16++;
    end

    // Reference model state
    logic [15:0] lv;
    int idx8, idx16;
    int exp_fd8 = 0;
    int exp_fd16 = 0;
    logic q8[$];
    logic q16[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input int n, input int idx);
        if (idx < n) return ~lv[idx];
        return 1'b0;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp();
        q8.push_back(exp_bit(8, idx8));
        q16.push_back(exp_bit(16, idx16));
    endtask

    task automatic pop_cmp(input string tag);
        logic e;
        if (q8.size() == 0 || q16.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = q8.pop_front();
        chk({tag, "_d8"}, d8, e);
        chk({tag, "_bc8"}, bc8, idx8);
        e = q16.pop_front();
        chk({tag, "_d16"}, d16, e);
        chk({tag, "_bc16"}, bc16, idx16);
    endtask

    task automatic do_latch(input logic [15:0] b_during, input logic [15:0] b_last,
                            input logic [15:0] b_after);
        btn = b_during;
        nes_latch = 1'b1;
        cyc(12);
        nes_latch = 1'b0;
        cyc(1);
        btn = b_last;
        cyc(1);
        btn = b_after;
        lv = b_last;
        idx8 = 0;
        idx16 = 0;
        push_exp();
        cyc(4);
        pop_cmp("latch");
    endtask

    task automatic clk_pulse();
        bit hit8, hit16;
        hit8 = 1'b0;
        hit16 = 1'b0;
        nes_clk = 1'b1;
        if (idx8 < 8) begin
            idx8++;
            if (idx8 == 8) begin hit8 = 1'b1; exp_fd8++; end
        end
        if (idx16 < 16) begin
            idx16++;
            if (idx16 == 16) begin hit16 = 1'b1; exp_fd16++; end
        end
        push_exp();
        cyc(2);
        if (hit8)  chk("fd8_early", fd8, 1'b0);
        if (hit16) chk("fd16_early", fd16, 1'b0);
        cyc(1);
        if (hit8)  chk("fd8_pulse", fd8, 1'b1);
        if (hit16) chk("fd16_pulse", fd16, 1'b1);
        cyc(1);
        if (hit8)  chk("fd8_width", fd8, 1'b0);
        if (hit16) chk("fd16_width", fd16, 1'b0);
        cyc(4);
        nes_clk = 1'b0;
        cyc(8);
        pop_cmp("bit");
        chk("fd8_count", fd_cnt8, exp_fd8);
        chk("fd16_count", fd_cnt16, exp_fd16);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset with latch high and shift clock toggling
        btn = 16'h0005;
        nes_latch = 1'b1;
        nes_clk = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            nes_clk = ~nes_clk;
        end
        @(negedge clk);
        chk("rst_d8", d8, 1'b1);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_bc8", bc8, 5'd0);
        chk("rst_d16", d16, 1'b1);
        chk("rst_busy16", busy16, 1'b0);
        chk("rst_fd8_count", fd_cnt8, 0);
        chk("rst_fd16_count", fd_cnt16, 0);
        rst_n = 1'b1;
        nes_clk = 1'b0;
        cyc(2);
        chk("rel_busy_pre", busy8, 1'b0);
        cyc(1);
        chk("rel_busy_load", busy8, 1'b1);

        // NES frame plus one extra pulse
        do_latch(16'h0005, 16'h0005, 16'h0005);
        for (int i = 0; i < 9; i++) clk_pulse();

        // Late button change: only the last latched value counts
        do_latch(16'h0000, 16'h0001, 16'h00FF);
        for (int i = 0; i < 8; i++) clk_pulse();

        // Mid-frame relatch
        do_latch(16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) clk_pulse();
        do_latch(16'h0080, 16'h0080, 16'h0080);
        chk("relatch_fd8_count", fd_cnt8, exp_fd8);
        for (int i = 0; i < 8; i++) clk_pulse();

        // SNES frame
        do_latch(16'h8001, 16'h8001, 16'h8001);
        for (int i = 0; i < 16; i++) clk_pulse();

        // Latch and shift edge synchronised in the same cycle at bit_count 5
        do_latch(16'h00F0, 16'h00F0, 16'h00F0);
        for (int i = 0; i < 5; i++) clk_pulse();
        btn = 16'h0002;
        nes_latch = 1'b1;
        nes_clk = 1'b1;
        cyc(3);
        chk("prio_bc8", bc8, 5'd0);
        chk("prio_bc16", bc16, 5'd0);
        chk("prio_busy8", busy8, 1'b1);
        chk("prio_d8", d8, 1'b1);
        do_latch(16'h0002, 16'h0002, 16'h0002);
        nes_clk = 1'b0;
        cyc(8);
        for (int i = 0; i < 2; i++) clk_pulse();
        chk("final_fd8_count", fd_cnt8, exp_fd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
